lsu_load_aligner: RTL and testbench
===================================

Name: lsu_load_aligner

Overview:
Read-side partner of the LSU byte-lane decoder. It accepts one load request at a time, carrying the byte-lane select and the access size. It encodes the lane select back to a byte offset and cross-checks that offset against the address. It then issues a word read to data memory, waits for a variable-latency response, and extracts, aligns and sign- or zero-extends the loaded bytes. The result goes to writeback over a valid/ready handshake.

Parameters:
TIMEOUT_CYCLES, 16, maximum WAIT cycles without i_mem_rvalid before an error response (must be >= 2).

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_reset  in  1  synchronous, active-high reset
i_req_valid  in  1  load request present
o_req_ready  out  1  block can accept a request (high only in IDLE)
i_req_addr  in  32  byte address
i_req_lane  in  4  byte-lane select from the 2-to-4 lane decoder path
i_req_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
i_req_rd  in  5  destination register tag
o_mem_rd_en  out  1  one-cycle read strobe
o_mem_addr  out  32  word address {addr[31:2],2'b00}
i_mem_rvalid  in  1  read data valid
i_mem_rdata  in  32  read word
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  writeback accepts response
o_rsp_data  out  32  aligned, extended load data
o_rsp_rd  out  5  captured rd tag
o_rsp_err  out  1  misaligned, illegal funct3, lane mismatch, or timeout

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset: state=IDLE, all outputs 0 except o_req_ready=1, timeout counter=0.
- IDLE:
  - A request is accepted when i_req_valid && o_req_ready. On acceptance, capture addr, lane, funct3 and rd.
  - Legality check, all must hold:
    - funct3 is in the legal set.
    - Lane pattern matches size: byte is one-hot; half is 0011 or 1100; word is 1111.
    - enc(lane) == addr[1:0], where enc gives the index of the lowest set lane bit.
  - Legal request: go to ISSUE. Illegal request: go directly to RESP with err=1, data=0, and no memory access.
- ISSUE:
  - o_mem_rd_en=1 for exactly this cycle; o_mem_addr valid.
  - Next state WAIT; counter cleared.
- WAIT:
  - o_mem_addr is held stable.
  - i_mem_rvalid: capture the extracted data and go to RESP with err=0.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 with no rvalid, go to RESP with err=1 and data=0.
  - If rvalid arrives in the timeout cycle, rvalid wins.
- RESP:
  - o_rsp_valid=1; data, rd and err are held stable until i_rsp_ready.
  - On the handshake, go to IDLE. o_req_ready returns the next cycle; there is no same-cycle re-accept.
- Data extraction, with off = captured addr[1:0]:
  - Byte = rdata[8*off +: 8].
  - Half = rdata[16*off[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- i_mem_rvalid outside WAIT (including in ISSUE) is ignored.
- Minimum latency: accept at cycle 0, ISSUE at 1, rvalid at 2, o_rsp_valid at 3. Illegal requests give o_rsp_valid at cycle 1.
- Reset mid-operation: return to IDLE immediately. No response is produced, and any later rvalid is ignored.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 load constants;
  - lane pattern constants (LANE_B0..B3, LANE_HLO, LANE_HHI, LANE_W);
  - state enum type.
- Sub-module encoder_4to2: 4-bit lane in, 2-bit offset plus a nonzero flag out, lowest-set-bit priority. Purely combinational; used for the cross-check.

Test Plan:
- LB, addr 0x103, lane 1000, rdata 0x80FF1234, rvalid in the cycle after ISSUE → mem_addr 0x100, rd_en pulses once, rsp_data 0xFFFFFF80, err 0, rsp_valid at cycle 3.
- LHU then LH, addr 0x202, lane 1100, rdata 0xBEEF0000 → 0x0000BEEF, then 0xFFFFBEEF.
- LW, addr 0x101, lane 1111 → no rd_en, rsp_valid at cycle 1, err 1, data 0. Repeat with LB addr 0x102, lane 0001 (lane mismatch) → same error response.
- TIMEOUT_CYCLES=8 with no rvalid → err 1 on entering RESP after 8 WAIT cycles. Repeat with rvalid on the 8th WAIT cycle → normal data, err 0.
- Hold rsp_ready low for 5 cycles and inject stray rvalid/rdata changes → rsp data/rd/err stable, req_ready 0, and a new req_valid is not accepted until after the handshake.
- Assert i_reset during WAIT, then rvalid 2 cycles later → rsp_valid never asserts, req_ready=1 after reset.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared load-unit constants: funct3 load encodings, byte-lane patterns and FSM state type.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] LANE_B0  = 4'b0001;
  localparam logic [3:0] LANE_B1  = 4'b0010;
  localparam logic [3:0] LANE_B2  = 4'b0100;
  localparam logic [3:0] LANE_B3  = 4'b1000;
  localparam logic [3:0] LANE_HLO = 4'b0011;
  localparam logic [3:0] LANE_HHI = 4'b1100;
  localparam logic [3:0] LANE_W   = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/encoder_4to2.sv
// Lane-select to byte-offset encoder; the lowest set lane bit wins.
module encoder_4to2 (
  input  logic [3:0] lane,
  output logic [1:0] off,
  output logic       nz
);

  always_comb begin
    nz  = |lane;
    off = 2'd0;
    if (lane[0])      off = 2'd0;
    else if (lane[1]) off = 2'd1;
    else if (lane[2]) off = 2'd2;
    else if (lane[3]) off = 2'd3;
  end

endmodule

// File: rtl/lsu_load_aligner.sv
// Load aligner: validates lane/size/offset, issues a word read, then extracts and extends the loaded bytes.
module lsu_load_aligner
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [3:0]  i_req_lane,
  input  logic [2:0]  i_req_funct3,
  input  logic [4:0]  i_req_rd,
  output logic        o_mem_rd_en,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic [4:0]  o_rsp_rd,
  output logic        o_rsp_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q;
  logic [2:0]       funct3_q;
  logic [4:0]       rd_q;
  logic [31:0]      data_q;
  logic             err_q;

  logic [1:0]       lane_off;
  logic             lane_nz;
  logic             req_legal;

  function automatic logic funct3_ok(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: funct3_ok = 1'b1;
      default:                             funct3_ok = 1'b0;
    endcase
  endfunction

  // Size comes from funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic lane_ok(input logic [2:0] f3, input logic [3:0] lane);
    case (f3[1:0])
      2'b00:   lane_ok = (lane == LANE_B0) || (lane == LANE_B1) ||
                         (lane == LANE_B2) || (lane == LANE_B3);
      2'b01:   lane_ok = (lane == LANE_HLO) || (lane == LANE_HHI);
      2'b10:   lane_ok = (lane == LANE_W);
      default: lane_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] rdata, input logic [1:0] off,
                                          input logic [2:0] f3);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = rdata >> {off, 3'b000};
    b = shifted[7:0];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      F3_LB:   extract = {{24{b[7]}}, b};
      F3_LBU:  extract = {24'd0, b};
      F3_LH:   extract = {{16{h[15]}}, h};
      F3_LHU:  extract = {16'd0, h};
      default: extract = rdata;
    endcase
  endfunction

  encoder_4to2 u_enc (
    .lane (i_req_lane),
    .off  (lane_off),
    .nz   (lane_nz)
  );

  assign req_legal = funct3_ok(i_req_funct3) && lane_ok(i_req_funct3, i_req_lane) &&
                     lane_nz && (lane_off == i_req_addr[1:0]);

  assign o_req_ready = (state == ST_IDLE);
  assign o_mem_rd_en = (state == ST_ISSUE);
  assign o_rsp_valid = (state == ST_RESP);
  assign o_mem_addr  = {addr_q[31:2], 2'b00};
  assign o_rsp_data  = data_q;
  assign o_rsp_rd    = rd_q;
  assign o_rsp_err   = err_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_req_valid) begin
            addr_q   <= i_req_addr;
            funct3_q <= i_req_funct3;
            rd_q     <= i_req_rd;
            if (req_legal) begin
              state <= ST_ISSUE;
            end else begin
              // Illegal requests never touch memory.
              state  <= ST_RESP;
              data_q <= '0;
              err_q  <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
          cnt   <= '0;
        end
        ST_WAIT: begin
          if (i_mem_rvalid) begin
            state  <= ST_RESP;
            data_q <= extract(i_mem_rdata, addr_q[1:0], funct3_q);
            err_q  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state  <= ST_RESP;
            data_q <= '0;
            err_q  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_load_aligner.sv
// Directed bench for lsu_load_aligner with a queue-based response scoreboard.
module tb_lsu_load_aligner;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic [3:0]  i_req_lane;
  logic [2:0]  i_req_funct3;
  logic [4:0]  i_req_rd;
  logic        o_mem_rd_en;
  logic [31:0] o_mem_addr;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_data;
  logic [4:0]  o_rsp_rd;
  logic        o_rsp_err;

  always #5 clk = ~clk;

  lsu_load_aligner #(.TIMEOUT_CYCLES(8)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_addr   (i_req_addr),
    .i_req_lane   (i_req_lane),
    .i_req_funct3 (i_req_funct3),
    .i_req_rd     (i_req_rd),
    .o_mem_rd_en  (o_mem_rd_en),
    .o_mem_addr   (o_mem_addr),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_data   (o_rsp_data),
    .o_rsp_rd     (o_rsp_rd),
    .o_rsp_err    (o_rsp_err)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   rden_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!i_reset && o_mem_rd_en) rden_cnt++;
  end

  // Monitor: pops one expected response per writeback handshake.
  always @(negedge clk) begin
    if (!i_reset && o_rsp_valid && i_rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", {o_rsp_err, 26'd0, o_rsp_rd}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_data", o_rsp_data, mon_e.data);
        chk("rsp_rd", 32'(o_rsp_rd), 32'(mon_e.rd));
        chk("rsp_err", 32'(o_rsp_err), 32'(mon_e.err));
      end
    end
  end

  task automatic wait_handshake(input string nm);
    int n;
    n = 0;
    while (o_rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_hs_done"}, 32'(o_rsp_valid), 32'd0);
  endtask

  task automatic do_load(input string nm, input logic [31:0] addr, input logic [3:0] lane,
                         input logic [2:0] f3, input logic [4:0] rd, input bit legal,
                         input int rv_at, input logic [31:0] rdata, input logic [31:0] exp_data,
                         input bit exp_err, input bit stray_issue, input bit hold);
    int rd0;
    rd0 = rden_cnt;
    @(posedge clk); #1;
    chk({nm, "_req_ready"}, 32'(o_req_ready), 32'd1);
    i_rsp_ready  = hold ? 1'b0 : 1'b1;
    i_req_valid  = 1'b1;
    i_req_addr   = addr;
    i_req_lane   = lane;
    i_req_funct3 = f3;
    i_req_rd     = rd;
    exp_q.push_back('{data: exp_data, rd: rd, err: exp_err});
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    if (!legal) begin
      chk({nm, "_c1_rsp_valid"}, 32'(o_rsp_valid), 32'd1);
      chk({nm, "_c1_rd_en"}, 32'(o_mem_rd_en), 32'd0);
    end else begin
      chk({nm, "_c1_rd_en"}, 32'(o_mem_rd_en), 32'd1);
      chk({nm, "_c1_mem_addr"}, o_mem_addr, {addr[31:2], 2'b00});
      chk({nm, "_c1_rsp_valid"}, 32'(o_rsp_valid), 32'd0);
      if (stray_issue) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h5A5A_5A5A;
      end
      @(posedge clk); #1;
      i_mem_rvalid = 1'b0;
      chk({nm, "_wait_rd_en"}, 32'(o_mem_rd_en), 32'd0);
      chk({nm, "_wait_mem_addr"}, o_mem_addr, {addr[31:2], 2'b00});
      if (rv_at >= 0) begin
        repeat (rv_at) begin
          chk({nm, "_wait_rsp_valid"}, 32'(o_rsp_valid), 32'd0);
          @(posedge clk); #1;
        end
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = rdata;
        @(posedge clk); #1;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = 32'hFFFF_FFFF;
      end else begin
        repeat (8) begin
          chk({nm, "_wait_rsp_valid"}, 32'(o_rsp_valid), 32'd0);
          @(posedge clk); #1;
        end
      end
      chk({nm, "_resp_valid"}, 32'(o_rsp_valid), 32'd1);
    end
    if (hold) begin
      repeat (5) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = $urandom;
        i_req_valid  = 1'b1;
        i_req_addr   = 32'h0000_0300;
        i_req_lane   = 4'b1111;
        i_req_funct3 = 3'b010;
        i_req_rd     = 5'd30;
        chk({nm, "_hold_data"}, o_rsp_data, exp_data);
        chk({nm, "_hold_rd"}, 32'(o_rsp_rd), 32'(rd));
        chk({nm, "_hold_err"}, 32'(o_rsp_err), 32'(exp_err));
        chk({nm, "_hold_req_ready"}, 32'(o_req_ready), 32'd0);
        chk({nm, "_hold_rsp_valid"}, 32'(o_rsp_valid), 32'd1);
        @(posedge clk); #1;
      end
      i_mem_rvalid = 1'b0;
      i_rsp_ready  = 1'b1;
      @(posedge clk); #1;
      chk({nm, "_post_hs_idle"}, 32'(o_req_ready), 32'd1);
      chk({nm, "_post_hs_rd_en"}, 32'(o_mem_rd_en), 32'd0);
      i_req_valid = 1'b0;
    end
    wait_handshake(nm);
    chk({nm, "_rd_en_pulses"}, 32'(rden_cnt - rd0), legal ? 32'd1 : 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset      = 1'b1;
    i_req_valid  = 1'b0;
    i_req_addr   = '0;
    i_req_lane   = '0;
    i_req_funct3 = '0;
    i_req_rd     = '0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = '0;
    i_rsp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_reset = 1'b0;
    chk("reset_req_ready", 32'(o_req_ready), 32'd1);
    chk("reset_rd_en", 32'(o_mem_rd_en), 32'd0);
    chk("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("reset_rsp_data", o_rsp_data, 32'd0);
    chk("reset_rsp_err", 32'(o_rsp_err), 32'd0);
    chk("reset_rsp_rd", 32'(o_rsp_rd), 32'd0);
    chk("reset_mem_addr", o_mem_addr, 32'd0);

    do_load("lb_sext",   32'h103, 4'b1000, 3'b000, 5'd5,  1, 0,  32'h80FF_1234, 32'hFFFF_FF80, 0, 0, 0);
    do_load("lhu_hi",    32'h202, 4'b1100, 3'b101, 5'd6,  1, 0,  32'hBEEF_0000, 32'h0000_BEEF, 0, 0, 0);
    do_load("lh_hi",     32'h202, 4'b1100, 3'b001, 5'd7,  1, 0,  32'hBEEF_0000, 32'hFFFF_BEEF, 0, 0, 0);
    do_load("lw_misal",  32'h101, 4'b1111, 3'b010, 5'd8,  0, 0,  32'h0,         32'h0,         1, 0, 0);
    do_load("lb_lanemm", 32'h102, 4'b0001, 3'b000, 5'd3,  0, 0,  32'h0,         32'h0,         1, 0, 0);
    do_load("lbu_stray", 32'h101, 4'b0010, 3'b100, 5'd9,  1, 1,  32'h0000_A500, 32'h0000_00A5, 0, 1, 0);
    do_load("bad_f3",    32'h100, 4'b1111, 3'b011, 5'd10, 0, 0,  32'h0,         32'h0,         1, 0, 0);
    do_load("lh_badpat", 32'h201, 4'b0110, 3'b001, 5'd4,  0, 0,  32'h0,         32'h0,         1, 0, 0);
    do_load("timeout",   32'h500, 4'b1111, 3'b010, 5'd11, 1, -1, 32'h0,         32'h0,         1, 0, 0);
    do_load("rv_last",   32'h504, 4'b1111, 3'b010, 5'd12, 1, 7,  32'h1234_5678, 32'h1234_5678, 0, 0, 0);
    do_load("hold",      32'h600, 4'b1111, 3'b010, 5'd13, 1, 0,  32'hCAFE_F00D, 32'hCAFE_F00D, 0, 0, 1);

    // Reset while waiting for memory: the response must be dropped.
    @(posedge clk); #1;
    i_req_valid  = 1'b1;
    i_req_addr   = 32'h400;
    i_req_lane   = 4'b1111;
    i_req_funct3 = 3'b010;
    i_req_rd     = 5'd14;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    @(posedge clk); #1;
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    chk("mid_reset_req_ready", 32'(o_req_ready), 32'd1);
    chk("mid_reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'h7777_7777;
    @(posedge clk); #1;
    i_mem_rvalid = 1'b0;
    repeat (4) begin
      chk("late_rv_rsp_valid", 32'(o_rsp_valid), 32'd0);
      chk("late_rv_req_ready", 32'(o_req_ready), 32'd1);
      @(posedge clk); #1;
    end

    do_load("lb_after_rst", 32'h100, 4'b0001, 3'b000, 5'd15, 1, 0, 32'h0000_007F, 32'h0000_007F, 0, 0, 0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
